// File: rtl/product_bcd_conv_if.sv
// rtl/product_bcd_conv_if.sv - product in / BCD result out handshake bundle
interface product_bcd_conv_if #(
  parameter int N = 4,
  parameter int D = 3
);
  logic             in_valid;
  logic [2*N-1:0]   in_data;
  logic             out_ready;
  logic             busy;
  logic             out_valid;
  logic [4*D-1:0]   bcd;
  logic             neg;

  // Upstream/downstream side: supplies the product, consumes the result
  modport master (
    output in_valid, in_data, out_ready,
    input  busy, out_valid, bcd, neg
  );

  // Converter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output busy, out_valid, bcd, neg
  );
endinterface

// File: rtl/product_bcd_conv.sv
// rtl/product_bcd_conv.sv - signed product to sign + BCD magnitude (double dabble); optional PBC_OVERRUN_EN
module product_bcd_conv #(
  parameter int N = 4,
  parameter int D = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  product_bcd_conv_if.slave     bus,
  output logic [2:0]            S
`ifdef PBC_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  localparam int W  = 2 * N;
  localparam int BW = 4 * D;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADJ   = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t          state;
  logic            in_prev;
  logic [W-1:0]    mag;
  logic [BW-1:0]   work;
  logic [CW-1:0]   cnt;

  logic            accept_ev;
  logic [W-1:0]    abs_in;
  logic [BW-1:0]   work_sh;

  // Rising edge of the upstream done level is the only thing that starts a conversion
  assign accept_ev = bus.in_valid & ~in_prev;
  // Most negative product wraps to 2^(W-1), which still fits as unsigned W bits
  assign abs_in    = bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;
  // Next work value: magnitude MSB shifts into the BCD digits
  assign work_sh   = {work[BW-2:0], mag[W-1]};
  assign S         = state;

  // Add 3 to every digit that would overflow past 9 after the next doubling
  function automatic logic [BW-1:0] bcd_adj(input logic [BW-1:0] w);
    logic [BW-1:0] r;
    r = w;
    for (int i = 0; i < D; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Conversion FSM: IDLE -> (ADJ -> SHIFT) x W -> DONE, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      in_prev       <= 1'b1;
      mag           <= '0;
      work          <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.bcd       <= '0;
      bus.neg       <= 1'b0;
`ifdef PBC_OVERRUN_EN
      overrun       <= 1'b0;
`endif
    end else begin
      in_prev <= bus.in_valid;
`ifdef PBC_OVERRUN_EN
      if (accept_ev && state != IDLE) overrun <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (accept_ev) begin
            bus.neg  <= bus.in_data[W-1];
            mag      <= abs_in;
            work     <= '0;
            cnt      <= CW'(W);
            bus.busy <= 1'b1;
            state    <= ADJ;
          end
        end
        ADJ: begin
          work  <= bcd_adj(work);
          state <= SHIFT;
        end
        SHIFT: begin
          work <= work_sh;
          mag  <= {mag[W-2:0], 1'b0};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.bcd       <= work_sh;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            state <= ADJ;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/product_bcd_conv.md
PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

Interface
REQ-001 Parameter N, default 4: multiplier operand width; the product is 2N bits, signed two's complement.
REQ-002 Parameter D, default 3: number of BCD output digits; D SHALL satisfy 10^D > 2^(2N-1).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 in_valid  input  1  product-available level from the upstream multiplier's done.
REQ-006 in_data  input  2N  signed product from the upstream multiplier's a output.
REQ-007 out_ready  input  1  downstream accepts the result.
REQ-008 busy  output  1  high while a conversion is in progress (ADJ or SHIFT).
REQ-009 out_valid  output  1  result valid; high in state DONE only.
REQ-010 bcd  output  4D  magnitude digits; digit 0 is in bits [3:0].
REQ-011 neg  output  1  sign of the captured product.
REQ-012 S  output  3  current state encoding, for debug.

Function
REQ-013 States SHALL be IDLE=0, ADJ=1, SHIFT=2, DONE=3; other encodings SHALL go to IDLE on the next edge.
REQ-014 A 1-bit register in_prev SHALL hold the previous in_valid; an accept event is in_valid=1 with in_prev=0.
REQ-015 The block SHALL take an accept event only in IDLE; accept events in other states SHALL be dropped.
REQ-016 On accept: neg<=in_data[2N-1]; magnitude<=|in_data| as 2N-bit unsigned (-2^(2N-1) gives 2^(2N-1)); BCD work register<=0; bit counter<=2N; state<=ADJ.
REQ-017 ADJ (1 cycle): each 4-bit work digit >=5 SHALL get +3; then state<=SHIFT.
REQ-018 SHIFT (1 cycle): {work, magnitude} SHALL shift left 1 bit; counter SHALL decrement; when the counter reaches 0, bcd<=shifted work and state<=DONE; otherwise state<=ADJ.
REQ-019 Latency: out_valid SHALL rise 4N edges after the accept edge (16 for N=4); a new accept is possible 1 edge after the out_ready handshake.
REQ-020 DONE: out_valid=1; when out_ready=1, state SHALL go to IDLE and out_valid to 0 on that edge.
REQ-021 bcd and neg SHALL hold their values from DONE until the next accept; bcd SHALL change only on the final SHIFT.
REQ-022 out_ready SHALL be ignored outside DONE; out_ready held low SHALL keep DONE indefinitely.
REQ-023 in_valid held high across conversions SHALL produce no further accepts until it falls and rises again.

Reset
REQ-024 With rst=0 at an edge: state=IDLE, busy=0, out_valid=0, bcd=0, neg=0, counter=0.
REQ-025 in_prev SHALL reset to 1, so an in_valid already high at reset release is not accepted.
REQ-026 Reset mid-conversion SHALL abandon the conversion with no out_valid pulse.
REQ-027 When rst=0 coincides with an accept event, reset SHALL take priority.

Configuration
REQ-028 Macro PBC_OVERRUN_EN.
 - Defined: adds output overrun (1 bit), set sticky when an accept event is dropped in a non-IDLE state, cleared only by reset.
 - Undefined: no overrun port; dropped accepts are silent; all other behaviour is identical.

Verification
REQ-029 N=4; in_data=8'h0C, in_valid rises, out_ready=1 -> out_valid rises 16 edges later, bcd=12'h012, neg=0, high for 1 cycle.
REQ-030 in_data=8'hF4 -> bcd=12'h012, neg=1; in_data=8'h80 -> bcd=12'h128, neg=1; 8'h7F -> 12'h127, neg=0; 8'h00 -> 12'h000, neg=0.
REQ-031 out_ready=0 for 10 cycles after out_valid -> out_valid and bcd stable; out_ready=1 -> IDLE next edge; bcd retained.
REQ-032 in_valid toggled low then high at the 5th edge of a conversion -> result unchanged; with PBC_OVERRUN_EN, overrun=1 until reset.
REQ-033 rst=0 for 1 edge during SHIFT with in_valid held high -> S=0, no out_valid, no new accept until in_valid falls and rises again.
